// File: rtl/mem_arb.sv
// Two-port (fetch / LSU) memory arbiter with one outstanding downstream transaction.
// Optional round-robin arbitration is enabled by defining COTM32_ARB_RR_EN.
module mem_arb #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_valid,
    output logic        if_ready,
    input  logic [31:0] if_addr,
    input  logic        ls_valid,
    output logic        ls_ready,
    input  logic [31:0] ls_addr,
    input  logic        ls_we,
    input  logic [31:0] ls_wdata,
    input  logic [3:0]  ls_wstrb,
    output logic        if_rsp_valid,
    output logic        ls_rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_addr,
    output logic [2:0]  m_sel,
    output logic        m_we,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    input  logic        m_rvalid,
    input  logic [31:0] m_rdata
);

    localparam logic [2:0] SEL_UNKNOWN = 3'd0;
    localparam logic [2:0] SEL_BOOTROM = 3'd1;
    localparam logic [2:0] SEL_CLINT   = 3'd2;
    localparam logic [2:0] SEL_UART    = 3'd3;
    localparam logic [2:0] SEL_DMEM    = 3'd4;
    localparam logic [7:0] WAIT_LAST   = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_RESP  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    function automatic logic [2:0] decode_target(input logic [31:0] addr);
        logic [2:0] sel;
        if (addr[31:12] == 20'h00000) begin
            sel = SEL_BOOTROM;
        end else if (addr[31:16] == 16'h0200) begin
            sel = SEL_CLINT;
        end else if (addr[31:8] == 24'h100000) begin
            sel = SEL_UART;
        end else if (addr[31:12] == 20'h80000) begin
            sel = SEL_DMEM;
        end else begin
            sel = SEL_UNKNOWN;
        end
        return sel;
    endfunction

    state_t      state_r;
    logic [31:0] addr_r;
    logic [2:0]  sel_r;
    logic        we_r;
    logic [31:0] wdata_r;
    logic [3:0]  wstrb_r;
    logic        owner_ls_r;
    logic [31:0] rdata_r;
    logic        err_r;
    logic [7:0]  cnt_r;
`ifdef COTM32_ARB_RR_EN
    logic        last_ls_r;
`endif

    logic        grant_ls_s;
    logic        grant_if_s;
    logic        accept_s;
    logic [31:0] sel_addr_s;
    logic        sel_we_s;
    logic [31:0] sel_wdata_s;
    logic [3:0]  sel_wstrb_s;
    logic [2:0]  target_s;
    logic        bad_s;

    // Arbitration between the two requesters.
    always_comb begin
        grant_ls_s = 1'b0;
        grant_if_s = 1'b0;
`ifdef COTM32_ARB_RR_EN
        if (if_valid && ls_valid) begin
            grant_ls_s = ~last_ls_r;
            grant_if_s = last_ls_r;
        end else begin
            grant_ls_s = ls_valid;
            grant_if_s = if_valid;
        end
`else
        grant_ls_s = ls_valid;
        grant_if_s = if_valid && !ls_valid;
`endif
    end

    assign accept_s = (state_r == S_IDLE) && rst_n;
    assign if_ready = accept_s && grant_if_s;
    assign ls_ready = accept_s && grant_ls_s;

    // Select the winning request fields; fetches are full-word reads.
    always_comb begin
        sel_addr_s  = 32'h0000_0000;
        sel_we_s    = 1'b0;
        sel_wdata_s = 32'h0000_0000;
        sel_wstrb_s = 4'hF;
        if (grant_ls_s) begin
            sel_addr_s  = ls_addr;
            sel_we_s    = ls_we;
            sel_wdata_s = ls_wdata;
            sel_wstrb_s = ls_wstrb;
        end else begin
            sel_addr_s  = if_addr;
        end
        target_s = decode_target(sel_addr_s);
        bad_s    = (target_s == SEL_UNKNOWN)
                || (sel_we_s && (target_s == SEL_BOOTROM))
                || (grant_if_s && (sel_addr_s[1:0] != 2'b00));
    end

    // Transaction FSM and latched request/response state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            addr_r     <= 32'h0000_0000;
            sel_r      <= SEL_UNKNOWN;
            we_r       <= 1'b0;
            wdata_r    <= 32'h0000_0000;
            wstrb_r    <= 4'h0;
            owner_ls_r <= 1'b0;
            rdata_r    <= 32'h0000_0000;
            err_r      <= 1'b0;
            cnt_r      <= 8'd0;
`ifdef COTM32_ARB_RR_EN
            last_ls_r  <= 1'b1;
`endif
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (if_ready || ls_ready) begin
                        addr_r     <= sel_addr_s;
                        sel_r      <= target_s;
                        we_r       <= sel_we_s;
                        wdata_r    <= sel_wdata_s;
                        wstrb_r    <= sel_wstrb_s;
                        owner_ls_r <= grant_ls_s;
                        state_r    <= bad_s ? S_ERR : S_ISSUE;
`ifdef COTM32_ARB_RR_EN
                        last_ls_r  <= grant_ls_s;
`endif
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    if (m_ready) begin
                        state_r <= S_WAIT;
                        cnt_r   <= 8'd0;
                    end else begin
                        state_r <= S_ISSUE;
                    end
                end
                S_WAIT: begin
                    if (m_rvalid) begin
                        rdata_r <= m_rdata;
                        err_r   <= 1'b0;
                        state_r <= S_RESP;
                    end else if (cnt_r == WAIT_LAST) begin
                        rdata_r <= 32'h0000_0000;
                        err_r   <= 1'b1;
                        state_r <= S_RESP;
                    end else begin
                        cnt_r   <= cnt_r + 8'd1;
                    end
                end
                S_RESP:  state_r <= S_IDLE;
                S_ERR:   state_r <= S_IDLE;
                default: state_r <= S_IDLE;
            endcase
        end
    end

    // Downstream request and shared response outputs are decoded from registered state only.
    always_comb begin
        m_valid      = (state_r == S_ISSUE);
        m_addr       = 32'h0000_0000;
        m_sel        = SEL_UNKNOWN;
        m_we         = 1'b0;
        m_wdata      = 32'h0000_0000;
        m_wstrb      = 4'h0;
        if (m_valid) begin
            m_addr  = addr_r;
            m_sel   = sel_r;
            m_we    = we_r;
            m_wdata = wdata_r;
            m_wstrb = wstrb_r;
        end else begin
            m_addr  = 32'h0000_0000;
        end
        if_rsp_valid = ((state_r == S_RESP) || (state_r == S_ERR)) && !owner_ls_r;
        ls_rsp_valid = ((state_r == S_RESP) || (state_r == S_ERR)) && owner_ls_r;
        rsp_err      = (state_r == S_ERR) || ((state_r == S_RESP) && err_r);
        rsp_rdata    = (state_r == S_RESP) ? rdata_r : 32'h0000_0000;
    end

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: a transaction-level latency model predicts every output each cycle.
module tb_mem_arb;
    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_valid = 1'b0, ls_valid = 1'b0, ls_we = 1'b0;
    logic [31:0] if_addr = 32'h0, ls_addr = 32'h0, ls_wdata = 32'h0;
    logic [3:0]  ls_wstrb = 4'h0;
    logic        m_ready = 1'b0, m_rvalid = 1'b0;
    logic [31:0] m_rdata = 32'h0;
    logic        if_ready, ls_ready, if_rsp_valid, ls_rsp_valid, rsp_err;
    logic        m_valid, m_we;
    logic [31:0] rsp_rdata, m_addr, m_wdata;
    logic [2:0]  m_sel;
    logic [3:0]  m_wstrb;

    mem_arb #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_valid(if_valid), .if_ready(if_ready), .if_addr(if_addr),
        .ls_valid(ls_valid), .ls_ready(ls_ready), .ls_addr(ls_addr),
        .ls_we(ls_we), .ls_wdata(ls_wdata), .ls_wstrb(ls_wstrb),
        .if_rsp_valid(if_rsp_valid), .ls_rsp_valid(ls_rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_sel(m_sel),
        .m_we(m_we), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_rvalid(m_rvalid), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        if_ready, ls_ready, m_valid;
        logic [31:0] m_addr;
        logic [2:0]  m_sel;
        logic        m_we;
        logic [31:0] m_wdata;
        logic [3:0]  m_wstrb;
        logic        if_rsp, ls_rsp, rsp_err;
        logic [31:0] rsp_rdata;
    } exp_t;

    exp_t exp_s;
    bit   exp_en = 1'b0;
    int   checks = 0, errors = 0, cyc = 0;
    int   acc_cyc = 0, hs_cyc = 0, rsp_cyc = 0;
    logic [2:0]  msel_seen = 3'd0;
    logic        err_seen = 1'b0;
    logic [31:0] data_seen = 32'h0;
    bit   grants[$];
    bit   model_last_ls = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, expv);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Observe DUT events for the literal checks, then compare every output to the model.
    always @(negedge clk) begin
        if (if_ready) begin grants.push_back(1'b0); acc_cyc = cyc; end
        if (ls_ready) begin grants.push_back(1'b1); acc_cyc = cyc; end
        if (m_valid && m_ready) hs_cyc = cyc;
        if (m_valid) msel_seen = m_sel;
        if (if_rsp_valid || ls_rsp_valid) begin
            rsp_cyc = cyc; err_seen = rsp_err; data_seen = rsp_rdata;
        end
        if (exp_en) begin
            chk("if_ready",     32'(if_ready),     32'(exp_s.if_ready));
            chk("ls_ready",     32'(ls_ready),     32'(exp_s.ls_ready));
            chk("m_valid",      32'(m_valid),      32'(exp_s.m_valid));
            chk("m_addr",       m_addr,            exp_s.m_addr);
            chk("m_sel",        32'(m_sel),        32'(exp_s.m_sel));
            chk("m_we",         32'(m_we),         32'(exp_s.m_we));
            chk("m_wdata",      m_wdata,           exp_s.m_wdata);
            chk("m_wstrb",      32'(m_wstrb),      32'(exp_s.m_wstrb));
            chk("if_rsp_valid", 32'(if_rsp_valid), 32'(exp_s.if_rsp));
            chk("ls_rsp_valid", 32'(ls_rsp_valid), 32'(exp_s.ls_rsp));
            chk("rsp_err",      32'(rsp_err),      32'(exp_s.rsp_err));
            chk("rsp_rdata",    rsp_rdata,         exp_s.rsp_rdata);
        end
    end

    // Address map expressed as plain inclusive ranges.
    function automatic logic [2:0] model_target(input logic [31:0] a);
        if (a <= 32'h0000_0FFF) return 3'd1;
        if (a >= 32'h0200_0000 && a <= 32'h0200_FFFF) return 3'd2;
        if (a >= 32'h1000_0000 && a <= 32'h1000_00FF) return 3'd3;
        if (a >= 32'h8000_0000 && a <= 32'h8000_0FFF) return 3'd4;
        return 3'd0;
    endfunction

    function automatic bit model_pick_ls(input bit ifv, input bit lsv);
`ifdef COTM32_ARB_RR_EN
        if (ifv && lsv) return !model_last_ls;
`endif
        return lsv;
    endfunction

    task automatic next();
        @(posedge clk);
        #1;
        exp_s = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        if_valid = 1'b0; ls_valid = 1'b0; m_ready = 1'b0; m_rvalid = 1'b0;
        next();
        exp_en = 1'b1;
        next();
        rst_n = 1'b1;
        model_last_ls = 1'b1;
    endtask

    // hold: 0 drop owner's valid after accept, 1 keep both, 2 keep then drop both in the response cycle.
    // rv_dly >= T means m_rvalid never comes; rst_at >= 0 asserts reset in that WAIT cycle.
    task automatic run_txn(input int hold, input int rdy_dly, input int rv_dly,
                           input logic [31:0] rdata, input int rst_at);
        bit is_ls, bad, tmo;
        logic [31:0] a, wd;
        logic [3:0] ws;
        logic we;
        logic [2:0] tgt;
        int nwait;
        is_ls = model_pick_ls(if_valid, ls_valid);
        model_last_ls = is_ls;
        a  = is_ls ? ls_addr : if_addr;
        we = is_ls ? ls_we : 1'b0;
        wd = is_ls ? ls_wdata : 32'h0;
        ws = is_ls ? ls_wstrb : 4'hF;
        tgt = model_target(a);
        bad = (tgt == 3'd0) || (we && tgt == 3'd1) || (!is_ls && a[1:0] != 2'b00);
        exp_s.if_ready = !is_ls;
        exp_s.ls_ready = is_ls;
        next();
        if (hold == 0) begin
            if (is_ls) ls_valid = 1'b0; else if_valid = 1'b0;
        end
        if (bad) begin
            exp_s.if_rsp = !is_ls; exp_s.ls_rsp = is_ls; exp_s.rsp_err = 1'b1;
            if (hold == 2) begin if_valid = 1'b0; ls_valid = 1'b0; end
            next();
            return;
        end
        for (int i = 0; i <= rdy_dly; i++) begin
            exp_s.m_valid = 1'b1; exp_s.m_addr = a; exp_s.m_sel = tgt;
            exp_s.m_we = we; exp_s.m_wdata = wd; exp_s.m_wstrb = ws;
            m_ready  = (i == rdy_dly);
            m_rvalid = (i == 0 && rdy_dly > 0);
            m_rdata  = 32'hBAD0_0000;
            next();
        end
        m_ready = 1'b0; m_rvalid = 1'b0;
        tmo = (rv_dly >= T);
        nwait = tmo ? T : rv_dly + 1;
        for (int j = 0; j < nwait; j++) begin
            if (rst_at == j) begin
                rst_n = 1'b0;
                next();
                rst_n = 1'b1;
                model_last_ls = 1'b1;
                m_rvalid = 1'b1; m_rdata = rdata;
                next();
                m_rvalid = 1'b0;
                next();
                return;
            end
            m_rvalid = !tmo && (j == rv_dly);
            m_rdata = rdata;
            next();
        end
        m_rvalid = 1'b0;
        exp_s.if_rsp = !is_ls; exp_s.ls_rsp = is_ls;
        exp_s.rsp_err = tmo;
        exp_s.rsp_rdata = tmo ? 32'h0 : rdata;
        if (hold == 2) begin if_valid = 1'b0; ls_valid = 1'b0; end
        next();
    endtask

    task automatic ls_req(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s);
        ls_valid = 1'b1; ls_addr = a; ls_we = w; ls_wdata = d; ls_wstrb = s;
    endtask

    initial begin
        int saved;
        bit order[4];
        exp_s = '0;
        do_reset();

        ls_req(32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF);
        run_txn(0, 0, 0, 32'h0, -1);
        chk("lat_write_dmem", 32'(rsp_cyc - acc_cyc), 32'd3);
        chk("sel_dmem", 32'(msel_seen), 32'd4);
        chk("err_write_dmem", 32'(err_seen), 32'd0);

        if_valid = 1'b1; if_addr = 32'h0000_0004;
        run_txn(0, 0, 0, 32'h0000_0013, -1);
        chk("sel_bootrom", 32'(msel_seen), 32'd1);
        chk("rdata_fetch", data_seen, 32'h0000_0013);

        ls_req(32'h0200_0040, 1'b0, 32'h5555_AAAA, 4'h3);
        run_txn(0, 2, 3, 32'h1234_5678, -1);
        chk("lat_stalled", 32'(rsp_cyc - acc_cyc), 32'd8);
        if_valid = 1'b1; if_addr = 32'h1000_00FC;
        run_txn(0, 0, 1, 32'hCAFE_0001, -1);
        ls_req(32'h8000_0FFC, 1'b0, 32'h0, 4'h1);
        run_txn(0, 0, 0, 32'h0BAD_F00D, -1);

        ls_req(32'h4000_0000, 1'b0, 32'h0, 4'hF);
        run_txn(0, 0, 0, 32'h0, -1);
        chk("lat_err_unknown", 32'(rsp_cyc - acc_cyc), 32'd1);
        chk("err_unknown", 32'(err_seen), 32'd1);
        ls_req(32'h0000_0000, 1'b1, 32'h1111_2222, 4'hF);
        run_txn(0, 0, 0, 32'h0, -1);
        chk("lat_err_romwr", 32'(rsp_cyc - acc_cyc), 32'd1);
        if_valid = 1'b1; if_addr = 32'h8000_0002;
        run_txn(0, 0, 0, 32'h0, -1);
        ls_req(32'h0000_1000, 1'b0, 32'h0, 4'hF);
        run_txn(0, 0, 0, 32'h0, -1);
        ls_req(32'h1000_0100, 1'b0, 32'h0, 4'hF);
        run_txn(0, 0, 0, 32'h0, -1);

        do_reset();
        grants.delete();
        if_valid = 1'b1; if_addr = 32'h0000_0100;
        ls_req(32'h8000_0200, 1'b0, 32'h0, 4'hF);
        for (int k = 0; k < 4; k++) run_txn((k == 3) ? 2 : 1, 0, 0, 32'h100 + 32'(k), -1);
        chk("grant_count", 32'(grants.size()), 32'd4);
        for (int k = 0; k < 4; k++) order[k] = (k < grants.size()) ? grants[k] : 1'b0;
`ifdef COTM32_ARB_RR_EN
        chk("grant_order", {28'h0, order[0], order[1], order[2], order[3]}, 32'h5);
`else
        chk("grant_order", {28'h0, order[0], order[1], order[2], order[3]}, 32'hF);
`endif

        ls_req(32'h8000_0020, 1'b0, 32'h0, 4'hF);
        run_txn(0, 0, 100, 32'h0, -1);
        chk("timeout_lat", 32'(rsp_cyc - hs_cyc), 32'd9);
        chk("timeout_err", 32'(err_seen), 32'd1);

        saved = rsp_cyc;
        ls_req(32'h8000_0024, 1'b0, 32'h0, 4'hF);
        run_txn(0, 0, 100, 32'h7777_7777, 2);
        chk("no_rsp_after_reset", 32'(rsp_cyc), 32'(saved));

        if_valid = 1'b1; if_addr = 32'h0000_0008;
        run_txn(0, 0, 0, 32'h0000_0093, -1);
        chk("recover_rdata", data_seen, 32'h0000_0093);

        exp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 255, max cycles in WAIT before error response (1..255).
REQ-002 SHALL have one clock and a synchronous, active-low reset; ports in order below.
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- if_valid  in  1  fetch request valid (read-only)
- if_ready  out  1  fetch request accepted
- if_addr  in  32  fetch byte address
- ls_valid  in  1  LSU request valid
- ls_ready  out  1  LSU request accepted
- ls_addr  in  32  LSU byte address
- ls_we  in  1  1 = write
- ls_wdata  in  32  write data
- ls_wstrb  in  4  byte enables
- if_rsp_valid  out  1  fetch response, one-cycle pulse
- ls_rsp_valid  out  1  LSU response, one-cycle pulse
- rsp_rdata  out  32  response read data, shared
- rsp_err  out  1  response error, shared, qualified by either rsp_valid
- m_valid  out  1  downstream request valid
- m_ready  in  1  downstream request accepted
- m_addr  out  32  downstream byte address
- m_sel  out  3  target, lsu_mem_src_t encoding
- m_we  out  1  downstream write
- m_wdata  out  32  downstream write data
- m_wstrb  out  4  downstream byte enables (4'hF for fetch reads)
- m_rvalid  in  1  downstream response valid (reads and writes)
- m_rdata  in  32  downstream read data

Function
REQ-003 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE, plus IDLE -> ERR -> IDLE; one transaction outstanding.
REQ-004 In IDLE with any valid, SHALL assert ready of the winner only, same cycle, and latch addr/we/wdata/wstrb/owner.
REQ-005 Both valid in IDLE: LSU wins (fixed priority) unless REQ-018 applies.
REQ-006 Decode: 0x0000_0000-0x0000_0FFF BOOTROM, 0x0200_0000-0x0200_FFFF CLINT, 0x1000_0000-0x1000_00FF UART, 0x8000_0000-0x8000_0FFF DMEM, else UNKNOWN.
REQ-007 UNKNOWN target, write to BOOTROM, or fetch with addr[1:0]!=0 SHALL go to ERR: no m_valid, response next cycle with rsp_err=1, rsp_rdata=0.
REQ-008 ISSUE: m_valid=1 with latched fields stable until m_valid&&m_ready; then WAIT.
REQ-009 WAIT: on m_rvalid, register m_rdata, go to RESP; m_rvalid outside WAIT SHALL be ignored.
REQ-010 RESP/ERR: owner's rsp_valid=1 for exactly one cycle; no response backpressure.
REQ-011 Min latency accept -> rsp_valid: 3 cycles (accept N, handshake N+1, m_rvalid N+2, rsp N+3); ERR path: 1 cycle.
REQ-012 WAIT counter (8 bit) reset on entry; reaching TIMEOUT_CYCLES without m_rvalid SHALL give error response, rsp_rdata=0.
REQ-013 Ready outputs SHALL be 0 outside IDLE; requesters hold request stable while valid && !ready.
REQ-014 Request valid in RESP/ERR cycle SHALL be arbitrated on the following IDLE cycle (no same-cycle back-to-back).

Reset
REQ-015 rst_n=0 at a rising edge SHALL force IDLE; all outputs 0; counter 0; in-flight transaction dropped, no response.
REQ-016 m_rvalid arriving after reset for a dropped transaction SHALL be ignored.

Configuration
REQ-017 Macro COTM32_ARB_RR_EN selects arbitration policy.
REQ-018 Defined: round robin; on contention, port not granted last wins; last-grant resets to LSU (fetch wins first contention). Undefined: REQ-005 fixed priority, no last-grant state.

Verification
REQ-019 ls_valid, ls_addr=0x8000_0010, ls_we=1, wdata=0xDEADBEEF, wstrb=4'hF; m_ready=1, m_rvalid next cycle -> m_sel=DMEM, ls_rsp_valid at N+3, rsp_err=0.
REQ-020 if_addr=0x0000_0004, m_rdata=0x00000013 -> m_sel=BOOTROM, if_rsp_valid pulse, rsp_rdata=0x00000013.
REQ-021 ls_addr=0x4000_0000 read -> no m_valid, ls_rsp_valid at N+1, rsp_err=1; ls write 0x0000_0000 -> same.
REQ-022 Both valid for 4 transactions -> fixed: LSU,LSU,LSU,LSU; with COTM32_ARB_RR_EN: IF,LS,IF,LS.
REQ-023 m_rvalid never asserted, TIMEOUT_CYCLES=8 -> rsp_err=1 eight cycles after WAIT entry; rst_n=0 in WAIT -> no response, outputs 0.
